// File: rtl/aux_input_pkg.sv
// aux_input_pkg: shared definitions for the board-input conditioner.
//   aux_hs_state_e          - request handshake FSM state encoding
//   AUX_DEB_CNT_DEFAULT     - debounce stable-cycle count (10 ms at 100 MHz)
//   AUX_SYNC_STAGES_DEFAULT - synchronizer depth
package aux_input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } aux_hs_state_e;

  localparam int unsigned AUX_DEB_CNT_DEFAULT     = 1_000_000;
  localparam int unsigned AUX_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/aux_input_conditioner_if.sv
// aux_input_conditioner_if: four-phase req/ack handshake between the
// board-clock input conditioner and the core-clock enable logic.
//   req  - held resume request (conditioner -> consumer)
//   busy - conditioner handshake not idle (conditioner -> consumer)
//   ack  - acknowledge, asynchronous to the conditioner clock (consumer -> conditioner)
interface aux_input_conditioner_if;
  logic req;
  logic busy;
  logic ack;

  modport master (output req, output busy, input ack);
  modport slave  (input req, input busy, output ack);
endinterface

// File: rtl/aux_debounce_bit.sv
// aux_debounce_bit: synchronizer chain plus debounce counter for one raw input.
//   clk   - board clock
//   rst   - synchronous active-high reset
//   raw   - asynchronous, bouncy input
//   level - debounced level; changes only after DebCnt consecutive
//           synchronized samples that differ from the current level
module aux_debounce_bit #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned DebCnt     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int unsigned CntW = $clog2(DebCnt + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebCnt - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  sync_s;
  logic [CntW-1:0]       cnt_q;
  logic                  stable_q;

  assign sync_s = sync_q[SyncStages-1];
  assign level  = stable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], raw};
      if (sync_s == stable_q) begin
        // any return to the old level discards the partial count
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        stable_q <= sync_s;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/aux_input_conditioner.sv
// aux_input_conditioner: debounces the resume button and slide switches and
// turns each accepted button press into one four-phase req/ack request.
//   clk       - board clock
//   rst       - synchronous active-high reset
//   btn_raw   - raw resume button
//   swt_raw   - raw switches
//   swt       - debounced switch levels
//   btn_level - debounced button level
//   btn_rise  - one-cycle pulse on accepted 0->1 of btn_level
//   hs        - req/busy out, ack in (ack synchronized here, not debounced)
module aux_input_conditioner
  import aux_input_pkg::*;
#(
  parameter int unsigned NumSwt     = 16,
  parameter int unsigned SyncStages = AUX_SYNC_STAGES_DEFAULT,
  parameter int unsigned DebCnt     = AUX_DEB_CNT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_raw,
  input  logic [NumSwt-1:0]     swt_raw,
  output logic [NumSwt-1:0]     swt,
  output logic                  btn_level,
  output logic                  btn_rise,
  aux_input_conditioner_if.master hs
);

  logic                  stable_btn;
  logic                  stable_btn_d1_q;
  logic [SyncStages-1:0] ack_sync_q;
  logic                  ack_s;
  aux_hs_state_e         state_q;
  logic                  req_q;
  logic                  busy_q;

  for (genvar i = 0; i < NumSwt; i++) begin : g_swt
    aux_debounce_bit #(
      .SyncStages (SyncStages),
      .DebCnt     (DebCnt)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (swt_raw[i]),
      .level (swt[i])
    );
  end

  aux_debounce_bit #(
    .SyncStages (SyncStages),
    .DebCnt     (DebCnt)
  ) u_deb_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_raw),
    .level (stable_btn)
  );

  assign btn_level = stable_btn;
  // both terms are flops, so the pulse is glitch-free
  assign btn_rise  = stable_btn & ~stable_btn_d1_q;
  assign ack_s     = ack_sync_q[SyncStages-1];
  assign hs.req    = req_q;
  assign hs.busy   = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync_q      <= '0;
      stable_btn_d1_q <= 1'b0;
      state_q         <= ST_IDLE;
      req_q           <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      ack_sync_q      <= {ack_sync_q[SyncStages-2:0], hs.ack};
      stable_btn_d1_q <= stable_btn;
      case (state_q)
        ST_IDLE: begin
          // ack_s high while idle is stale and ignored
          if (btn_rise) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_REQ: begin
          // presses arriving here are dropped, not queued
          if (ack_s) begin
            state_q <= ST_WAIT_LOW;
            req_q   <= 1'b0;
          end
        end
        ST_WAIT_LOW: begin
          if (!ack_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aux_input_conditioner.sv
// tb_aux_input_conditioner: directed scenarios plus randomized stimulus,
// checked every cycle against a behavioural model (sample delay lines,
// run-length debounce, flag-based handshake).
module tb_aux_input_conditioner;

  localparam int unsigned NumSwt     = 16;
  localparam int unsigned SyncStages = 2;
  localparam int unsigned DebCnt     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              btn_raw;
  logic [NumSwt-1:0] swt_raw;
  logic [NumSwt-1:0] swt;
  logic              btn_level;
  logic              btn_rise;

  int checks = 0;
  int errors = 0;

  aux_input_conditioner_if hs ();

  aux_input_conditioner #(
    .NumSwt     (NumSwt),
    .SyncStages (SyncStages),
    .DebCnt     (DebCnt)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .swt_raw   (swt_raw),
    .swt       (swt),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .hs        (hs)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // bit NumSwt of the input vectors is the button
  logic [NumSwt:0] in_hist [SyncStages] = '{default: '0};
  logic            ack_hist [SyncStages] = '{default: 1'b0};
  logic [NumSwt:0] m_stable = '0;
  int              m_run [NumSwt+1] = '{default: 0};
  logic            m_prev = 1'b0;
  logic            m_req  = 1'b0;
  logic            m_busy = 1'b0;

  always @(posedge clk) begin
    logic [NumSwt:0] seen;
    logic            ack_seen;
    logic            rise_seen;
    seen      = in_hist[SyncStages-1];
    ack_seen  = ack_hist[SyncStages-1];
    rise_seen = m_stable[NumSwt] & ~m_prev;
    if (rst) begin
      for (int k = 0; k < SyncStages; k++) begin
        in_hist[k]  = '0;
        ack_hist[k] = 1'b0;
      end
      m_stable = '0;
      for (int i = 0; i <= NumSwt; i++) m_run[i] = 0;
      m_prev = 1'b0;
      m_req  = 1'b0;
      m_busy = 1'b0;
    end else begin
      if (!m_busy) begin
        if (rise_seen) begin
          m_req  = 1'b1;
          m_busy = 1'b1;
        end
      end else if (m_req) begin
        if (ack_seen) m_req = 1'b0;
      end else if (!ack_seen) begin
        m_busy = 1'b0;
      end
      m_prev = m_stable[NumSwt];
      for (int i = 0; i <= NumSwt; i++) begin
        if (seen[i] == m_stable[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == int'(DebCnt)) begin
            m_stable[i] = seen[i];
            m_run[i]    = 0;
          end
        end
      end
      for (int k = SyncStages - 1; k > 0; k--) begin
        in_hist[k]  = in_hist[k-1];
        ack_hist[k] = ack_hist[k-1];
      end
      in_hist[0]  = {btn_raw, swt_raw};
      ack_hist[0] = hs.ack;
    end
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check_val("swt", 32'(swt), 32'(m_stable[NumSwt-1:0]));
    check_val("btn_level", 32'(btn_level), 32'(m_stable[NumSwt]));
    check_val("btn_rise", 32'(btn_rise), 32'(m_stable[NumSwt] & ~m_prev));
    check_val("req", 32'(hs.req), 32'(m_req));
    check_val("busy", 32'(hs.busy), 32'(m_busy));
  endtask

  // one clock edge, then compare at the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int rises;
  logic [7:0] bounce_pat;

  initial begin
    rst     = 1'b1;
    btn_raw = 1'b1;
    swt_raw = 16'hFFFF;
    hs.ack  = 1'b0;

    // reset with everything held high
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_swt", 32'(swt), 32'h0);
      check_val("rst_btn", 32'(btn_level), 32'h0);
      check_val("rst_req", 32'(hs.req), 32'h0);
    end
    rst   = 1'b0;
    rises = 0;
    for (int e = 1; e <= 21; e++) begin
      tick();
      if (btn_rise) rises++;
      if (e == 5) check_val("acc_early_swt", 32'(swt), 32'h0);
      if (e == 6) begin
        check_val("acc_swt", 32'(swt), 32'hFFFF);
        check_val("acc_btn", 32'(btn_level), 32'h1);
        check_val("acc_rise", 32'(btn_rise), 32'h1);
      end
      if (e == 7) begin
        check_val("rise_once_cycle", 32'(btn_rise), 32'h0);
        check_val("req_up", 32'(hs.req), 32'h1);
      end
      if (e == 11) hs.ack = 1'b1;
      if (e == 13) check_val("req_hold", 32'(hs.req), 32'h1);
      if (e == 14) check_val("req_fall", 32'(hs.req), 32'h0);
      if (e == 18) hs.ack = 1'b0;
      if (e == 20) check_val("busy_hold", 32'(hs.busy), 32'h1);
      if (e == 21) check_val("busy_fall", 32'(hs.busy), 32'h0);
    end
    check_val("reset_rises", 32'(rises), 32'h1);

    btn_raw = 1'b0;
    swt_raw = '0;
    ticks(10);

    // glitch of 3 cycles on switch 3
    swt_raw[3] = 1'b1;
    ticks(3);
    swt_raw[3] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val("glitch_swt", 32'(swt), 32'h0);
    end
    // held long enough
    swt_raw[3] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) check_val("swt3_early", 32'(swt), 32'h0);
      if (e >= 6) check_val("swt3_acc", 32'(swt), 32'h8);
    end
    swt_raw[3] = 1'b0;
    ticks(8);

    // bounce on the last counting sample
    bounce_pat = 8'b1111_0111;  // applied LSB first: 1,1,1,0,1,1,1,1
    rises = 0;
    for (int e = 1; e <= 16; e++) begin
      btn_raw = (e <= 8) ? bounce_pat[e-1] : 1'b1;
      tick();
      if (btn_rise) rises++;
      if (e == 6) check_val("bounce_no_acc", 32'(btn_level), 32'h0);
      if (e == 9) check_val("bounce_late", 32'(btn_level), 32'h0);
      if (e == 10) check_val("bounce_acc", 32'(btn_level), 32'h1);
    end
    check_val("bounce_rises", 32'(rises), 32'h1);
    check_val("bounce_req", 32'(hs.req), 32'h1);

    // second press while REQ is pending is dropped
    btn_raw = 1'b0;
    ticks(8);
    btn_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val("drop_req", 32'(hs.req), 32'h1);
      check_val("drop_busy", 32'(hs.busy), 32'h1);
    end
    hs.ack = 1'b1;
    ticks(6);
    hs.ack = 1'b0;
    ticks(6);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("drop_no_second_req", 32'(hs.req), 32'h0);
      check_val("drop_idle", 32'(hs.busy), 32'h0);
    end

    // reset while a request is pending, button held through reset
    btn_raw = 1'b0;
    ticks(8);
    btn_raw = 1'b1;
    ticks(8);
    check_val("pend_req", 32'(hs.req), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rstpend_req", 32'(hs.req), 32'h0);
    check_val("rstpend_busy", 32'(hs.busy), 32'h0);
    check_val("rstpend_btn", 32'(btn_level), 32'h0);
    rises = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (btn_rise) rises++;
      if (e == 6) check_val("reacc_btn", 32'(btn_level), 32'h1);
    end
    check_val("reacc_rises", 32'(rises), 32'h1);
    check_val("reacc_req", 32'(hs.req), 32'h1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) btn_raw = 1'($urandom);
      if ($urandom_range(3) == 0) swt_raw[$urandom_range(NumSwt-1)] ^= 1'b1;
      if ($urandom_range(5) == 0) hs.ack = ~hs.ack;
      rst = ($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
